// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand-forwarding select and load-use stall controller
// Tracks in-flight destinations and registers the ALU operand mux selects for the EX cycle.
module fwd_hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rs,
  input  logic [REG_W-1:0] issue_rt,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             issue_regwrite,
  input  logic             issue_memread,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  // A WB slot is not kept: the register file is write-before-read, so a
  // distance-3 producer never needs a forward.
  logic             ex_valid;
  logic             ex_regwrite;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rd;
  logic             mem_valid;
  logic             mem_regwrite;
  logic [REG_W-1:0] mem_rd;

  logic             take;
  logic             ex_hit_a;
  logic             ex_hit_b;
  logic             mem_hit_a;
  logic             mem_hit_b;
  logic [1:0]       sel_a;
  logic [1:0]       sel_b;

  always_comb begin
    stall = ex_valid && ex_memread && ex_regwrite && (ex_rd != '0) &&
            ((ex_rd == id_rs) || (ex_rd == id_rt));
    take  = issue_valid && !stall && !flush;
  end

  always_comb begin
    ex_hit_a  = ex_valid  && ex_regwrite  && (issue_rs != '0) && (ex_rd  == issue_rs);
    ex_hit_b  = ex_valid  && ex_regwrite  && (issue_rt != '0) && (ex_rd  == issue_rt);
    mem_hit_a = mem_valid && mem_regwrite && (issue_rs != '0) && (mem_rd == issue_rs);
    mem_hit_b = mem_valid && mem_regwrite && (issue_rt != '0) && (mem_rd == issue_rt);

    // Nearer producer wins.
    sel_a = SEL_RF;
    if (ex_hit_a)       sel_a = SEL_EXMEM;
    else if (mem_hit_a) sel_a = SEL_MEMWB;

    sel_b = SEL_RF;
    if (ex_hit_b)       sel_b = SEL_EXMEM;
    else if (mem_hit_b) sel_b = SEL_MEMWB;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_rd        <= '0;
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_rd       <= '0;
      fwd_a        <= SEL_RF;
      fwd_b        <= SEL_RF;
      stall_cnt    <= '0;
    end else begin
      mem_valid    <= ex_valid;
      mem_regwrite <= ex_regwrite;
      mem_rd       <= ex_rd;

      ex_valid     <= take;
      ex_regwrite  <= take && issue_regwrite;
      ex_memread   <= take && issue_memread;
      ex_rd        <= take ? issue_rd : '0;

      fwd_a        <= take ? sel_a : SEL_RF;
      fwd_b        <= take ? sel_b : SEL_RF;

      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - self-checking bench for fwd_hazard_unit
// Directed scenarios plus randomized traffic against an instruction-history model.
module tb_fwd_hazard_unit;

  localparam int RW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue_valid;
  logic [RW-1:0] issue_rs, issue_rt, issue_rd;
  logic          issue_regwrite, issue_memread;
  logic [RW-1:0] id_rs, id_rt;
  logic          flush;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  // Model: h_*[d] is the instruction that entered EX d edges ago (d=0 is in EX).
  bit         h_v[3];
  bit         h_rw[3];
  bit         h_mr[3];
  int         h_rd[3];
  logic [1:0] e_a, e_b;
  int         e_cnt;

  fwd_hazard_unit #(.REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
    .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_rd(issue_rd),
    .issue_regwrite(issue_regwrite), .issue_memread(issue_memread),
    .id_rs(id_rs), .id_rt(id_rt), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit m_stall();
    return h_v[0] && h_mr[0] && h_rw[0] && (h_rd[0] != 0) &&
           ((h_rd[0] == int'(id_rs)) || (h_rd[0] == int'(id_rt)));
  endfunction

  function automatic logic [1:0] m_pick(input int r);
    if (r == 0) return 2'b00;
    for (int d = 0; d < 2; d++)
      if (h_v[d] && h_rw[d] && h_rd[d] == r) return (d == 0) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  task automatic tick();
    bit st, take;
    st = m_stall();
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) begin
        h_v[d] = 0; h_rw[d] = 0; h_mr[d] = 0; h_rd[d] = 0;
      end
      e_a = 2'b00; e_b = 2'b00; e_cnt = 0;
    end else begin
      take = issue_valid && !st && !flush;
      e_a = take ? m_pick(int'(issue_rs)) : 2'b00;
      e_b = take ? m_pick(int'(issue_rt)) : 2'b00;
      if (st && e_cnt != CMAX) e_cnt++;
      for (int d = 2; d > 0; d--) begin
        h_v[d] = h_v[d-1]; h_rw[d] = h_rw[d-1]; h_mr[d] = h_mr[d-1]; h_rd[d] = h_rd[d-1];
      end
      h_v[0] = take; h_rw[0] = issue_regwrite; h_mr[0] = issue_memread; h_rd[0] = int'(issue_rd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int rs, input int rt, input int rd, input bit rw,
                       input bit mr, input bit fl, input int irs, input int irt);
    issue_valid = v; issue_rs = RW'(rs); issue_rt = RW'(rt); issue_rd = RW'(rd);
    issue_regwrite = rw; issue_memread = mr; flush = fl;
    id_rs = RW'(irs); id_rt = RW'(irt);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      issue_valid = 1'($urandom); issue_rs = RW'($urandom); issue_rt = RW'($urandom);
      issue_rd = RW'($urandom); issue_regwrite = 1'($urandom); issue_memread = 1'($urandom);
      id_rs = RW'($urandom); id_rt = RW'($urandom); flush = 1'($urandom);
      tick();
    end
    tests++; if (fwd_a !== 2'b00) begin fails++; $display("FAIL reset_fwd_a: got %b want 00", fwd_a); end
    tests++; if (fwd_b !== 2'b00) begin fails++; $display("FAIL reset_fwd_b: got %b want 00", fwd_b); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
    tests++; if (stall_cnt !== '0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_ex_mem_fwd();
    drive(1, 0, 0, 3, 1, 0, 0, 0, 0);
    drive(1, 3, 4, 20, 1, 0, 0, 0, 0);
    tests++; if (fwd_a !== 2'b01) begin fails++; $display("FAIL exmem_fwd_a: got %b want 01", fwd_a); end
    tests++; if (fwd_b !== 2'b00) begin fails++; $display("FAIL exmem_fwd_b: got %b want 00", fwd_b); end
  endtask

  task automatic test_priority();
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0);
    drive(1, 5, 5, 20, 1, 0, 0, 0, 0);
    tests++; if (fwd_a !== 2'b01) begin fails++; $display("FAIL prio_fwd_a: got %b want 01", fwd_a); end
    tests++; if (fwd_b !== 2'b01) begin fails++; $display("FAIL prio_fwd_b: got %b want 01", fwd_b); end
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 6, 1, 0, 0, 0, 0);
    drive(1, 5, 5, 20, 1, 0, 0, 0, 0);
    tests++; if (fwd_a !== 2'b10) begin fails++; $display("FAIL memwb_fwd_a: got %b want 10", fwd_a); end
    tests++; if (fwd_b !== 2'b10) begin fails++; $display("FAIL memwb_fwd_b: got %b want 10", fwd_b); end
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, 7, 1, 1, 0, 7, 0);
    issue_valid = 1'b0;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall_on: got %b want 1", stall); end
    tests++; if (stall_cnt !== CW'(0)) begin fails++; $display("FAIL lu_cnt_before: got %0d want 0", stall_cnt); end
    tick();
    tests++; if (stall_cnt !== CW'(1)) begin fails++; $display("FAIL lu_cnt_after: got %0d want 1", stall_cnt); end
    tests++; if (fwd_a !== 2'b00) begin fails++; $display("FAIL lu_bubble_fwd: got %b want 00", fwd_a); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_stall_off: got %b want 0", stall); end
    drive(1, 7, 2, 20, 1, 0, 0, 0, 0);
    tests++; if (fwd_a !== 2'b10) begin fails++; $display("FAIL lu_dep_fwd_a: got %b want 10", fwd_a); end
    tests++; if (fwd_b !== 2'b00) begin fails++; $display("FAIL lu_dep_fwd_b: got %b want 00", fwd_b); end
    tests++; if (stall_cnt !== CW'(1)) begin fails++; $display("FAIL lu_cnt_hold: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_zero_dist3();
    drive(1, 0, 0, 0, 1, 1, 0, 0, 0);
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL zero_stall: got %b want 0", stall); end
    drive(1, 0, 0, 21, 1, 0, 0, 0, 0);
    tests++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      fails++; $display("FAIL zero_fwd: got %b/%b want 00/00", fwd_a, fwd_b);
    end
    drive(1, 0, 0, 11, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 22, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 23, 1, 0, 0, 0, 0);
    drive(1, 11, 22, 24, 1, 0, 0, 0, 0);
    tests++; if (fwd_a !== 2'b00) begin fails++; $display("FAIL dist3_fwd_a: got %b want 00", fwd_a); end
    tests++; if (fwd_b !== 2'b10) begin fails++; $display("FAIL dist2_fwd_b: got %b want 10", fwd_b); end
  endtask

  task automatic test_flush();
    drive(1, 0, 0, 8, 1, 0, 0, 0, 0);
    drive(1, 8, 8, 9, 1, 0, 1, 0, 0);
    tests++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
      fails++; $display("FAIL flush_edge_fwd: got %b/%b want 00/00", fwd_a, fwd_b);
    end
    drive(1, 9, 8, 20, 1, 0, 0, 0, 0);
    tests++; if (fwd_a !== 2'b00) begin fails++; $display("FAIL flush_fwd_a: got %b want 00", fwd_a); end
    tests++; if (fwd_b !== 2'b10) begin fails++; $display("FAIL flush_fwd_b: got %b want 10", fwd_b); end
  endtask

  task automatic test_saturation();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < CMAX + 5; i++) begin
      drive(1, 0, 0, 7, 1, 1, 0, 0, 7);
      issue_valid = 1'b0;
      tick();
    end
    tests++; if (stall_cnt !== CW'(CMAX)) begin
      fails++; $display("FAIL sat_cnt: got %0d want %0d", stall_cnt, CMAX);
    end
    tests++; if (int'(stall_cnt) != e_cnt) begin
      fails++; $display("FAIL sat_model: got %0d want %0d", stall_cnt, e_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_rs = RW'($urandom_range(0, 7)); issue_rt = RW'($urandom_range(0, 7));
      issue_rd = RW'($urandom_range(0, 7));
      issue_regwrite = ($urandom_range(0, 3) != 0);
      issue_memread = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      id_rs = RW'($urandom_range(0, 7)); id_rt = RW'($urandom_range(0, 7));
      #1;
      tests++; if (stall !== m_stall()) begin
        fails++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, stall, m_stall());
      end
      tick();
      tests++; if (fwd_a !== e_a || fwd_b !== e_b) begin
        fails++; $display("FAIL rnd_fwd[%0d]: got %b/%b want %b/%b", i, fwd_a, fwd_b, e_a, e_b);
      end
      tests++; if (int'(stall_cnt) != e_cnt) begin
        fails++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, stall_cnt, e_cnt);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_rs = '0; issue_rt = '0; issue_rd = '0;
    issue_regwrite = 1'b0; issue_memread = 1'b0; id_rs = '0; id_rt = '0; flush = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_ex_mem_fwd();
    test_priority();
    test_load_use();
    test_zero_dist3();
    test_flush();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
